// File: rtl/disp_capture_sched_pkg.sv
// Shared definitions for the display capture scheduler.
// Holds the time/frequency FSM state enums, the default capture sizes and
// the RAM address and sample widths used by every file of the block.
// No ports: this is a package.
package disp_pkg;

  localparam int ADDR_W           = 10;
  localparam int SAMPLE_W         = 8;
  localparam int DEF_NUM_TIME     = 640;
  localparam int DEF_NUM_FREQ     = 80;
  localparam int DEF_TRIG_TIMEOUT = 4096;

  typedef enum logic [1:0] {ARMED, CAPTURE, HOLD} time_state_e;
  typedef enum logic [1:0] {FWAIT, FFILL, FDONE} freq_state_e;

  // Highest legal RAM address for a buffer holding n entries.
  function automatic logic [ADDR_W-1:0] lastAddr(input int n);
    return ADDR_W'(n - 1);
  endfunction

endpackage

// File: rtl/disp_capture_sched_if.sv
// Bus bundle between the sample sources / display RAMs and the scheduler.
// Inputs to the scheduler: frmTick, timeVld/timeData, freqVld/freqFirst/freqData.
// Outputs of the scheduler: time RAM write port (enaTime, weaTime, addraTime,
// dinaTime), freq RAM write port (weaFreq, addraFreq, dinaFreq), timeBusy, capDone.
// master = the environment driving samples, slave = the scheduler.
interface disp_capture_sched_if;
  import disp_pkg::*;

  logic                frmTick;
  logic                timeVld;
  logic [SAMPLE_W-1:0] timeData;
  logic                freqVld;
  logic                freqFirst;
  logic [SAMPLE_W-1:0] freqData;

  logic                enaTime;
  logic                weaTime;
  logic [ADDR_W-1:0]   addraTime;
  logic [SAMPLE_W-1:0] dinaTime;
  logic                weaFreq;
  logic [ADDR_W-1:0]   addraFreq;
  logic [SAMPLE_W-1:0] dinaFreq;
  logic                timeBusy;
  logic                capDone;

  modport master (
    output frmTick, timeVld, timeData, freqVld, freqFirst, freqData,
    input  enaTime, weaTime, addraTime, dinaTime, weaFreq, addraFreq, dinaFreq,
           timeBusy, capDone
  );

  modport slave (
    input  frmTick, timeVld, timeData, freqVld, freqFirst, freqData,
    output enaTime, weaTime, addraTime, dinaTime, weaFreq, addraFreq, dinaFreq,
           timeBusy, capDone
  );

endinterface

// File: rtl/disp_capture_sched_trig_detect.sv
// Rising zero-crossing trigger with timeout for the time capture.
// Only compiled when DISP_CAPTURE_TRIG_EN is defined; the free-running build
// has no trigger hardware at all.
// Ports: clk, rst (async, active-high); clr_i clears prev and the timeout count;
// smpVld_i/smpData_i are samples accepted while armed; fire_o says the current
// sample starts a capture (crossing from negative to non-negative, or timeout).
`ifdef DISP_CAPTURE_TRIG_EN
module disp_trig_detect
  import disp_pkg::*;
#(
  parameter int TRIG_TIMEOUT = DEF_TRIG_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                smpVld_i,
  input  logic [SAMPLE_W-1:0] smpData_i,
  output logic                fire_o
);

  localparam int CntW = $clog2(TRIG_TIMEOUT + 1);

  logic [SAMPLE_W-1:0] prev_q, prev_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                crossing, timedOut;

  // Samples are two's complement, so the sign bits alone decide the crossing.
  // The counter saturates at TRIG_TIMEOUT; the next accepted sample then fires.
  always_comb begin
    crossing = prev_q[SAMPLE_W-1] && !smpData_i[SAMPLE_W-1];
    timedOut = (cnt_q == CntW'(TRIG_TIMEOUT));
    fire_o   = smpVld_i && (crossing || timedOut);
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      prev_d = '0;
      cnt_d  = '0;
    end else if (smpVld_i) begin
      prev_d = smpData_i;
      if (!timedOut) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/disp_capture_sched.sv
// Display capture scheduler: writes one screen of time samples and one frame
// of frequency bins into display RAMs, re-arming on the frame strobe.
// Ports: ck100MHz system clock; rst async active-high reset; bus (slave modport)
// carries frmTick, the time/freq sample streams, both RAM write ports,
// timeBusy and capDone. All outputs are registered.
// Macro DISP_CAPTURE_TRIG_EN: when defined, ARMED waits for a rising zero
// crossing (or a timeout); when undefined, capture starts on the first sample.
module disp_capture_sched
  import disp_pkg::*;
#(
  parameter int NUM_TIME     = DEF_NUM_TIME,
  parameter int NUM_FREQ     = DEF_NUM_FREQ,
  parameter int TRIG_TIMEOUT = DEF_TRIG_TIMEOUT
) (
  input  logic                 ck100MHz,
  input  logic                 rst,
  disp_capture_sched_if.slave  bus
);

  if (NUM_TIME < 1 || NUM_TIME > (1 << ADDR_W) || NUM_FREQ < 1 ||
      NUM_FREQ > (1 << ADDR_W) || TRIG_TIMEOUT < 1) begin : gBadCfg
    $error("disp_capture_sched: parameter out of range");
  end

  time_state_e         timeState_q;
  logic [ADDR_W-1:0]   timeAddr_q;
  logic                pending_q;
  logic                enaTime_q, weaTime_q, timeBusy_q, capDone_q;
  logic [ADDR_W-1:0]   addraTime_q;
  logic [SAMPLE_W-1:0] dinaTime_q;

  freq_state_e         freqState_q;
  logic [ADDR_W-1:0]   freqAddr_q;
  logic                weaFreq_q;
  logic [ADDR_W-1:0]   addraFreq_q;
  logic [SAMPLE_W-1:0] dinaFreq_q;

  logic                armFire, timeWrite, timeLast;
  logic [ADDR_W-1:0]   timeWrAddr;
  logic                freqWrite, freqLast;
  logic [ADDR_W-1:0]   freqWrAddr;

`ifdef DISP_CAPTURE_TRIG_EN
  // The detector only sees samples while armed and is held clear otherwise,
  // so every new arming starts with prev = 0 and a fresh timeout count.
  disp_trig_detect #(.TRIG_TIMEOUT(TRIG_TIMEOUT)) uTrig (
    .clk       (ck100MHz),
    .rst       (rst),
    .clr_i     (timeState_q != ARMED),
    .smpVld_i  (bus.timeVld && (timeState_q == ARMED)),
    .smpData_i (bus.timeData),
    .fire_o    (armFire)
  );
`else
  assign armFire = 1'b1;
`endif

  // The sample that starts a capture always lands at address 0; later samples
  // use the running counter. Both paths share the end-of-buffer test.
  always_comb begin
    timeWrAddr = (timeState_q == CAPTURE) ? timeAddr_q : '0;
    timeWrite  = bus.timeVld &&
                 ((timeState_q == CAPTURE) || ((timeState_q == ARMED) && armFire));
    timeLast   = (timeWrAddr == lastAddr(NUM_TIME));
    freqWrAddr = bus.freqFirst ? '0 : freqAddr_q;
    freqWrite  = bus.freqVld &&
                 (((freqState_q == FWAIT) && bus.freqFirst) || (freqState_q == FFILL));
    freqLast   = (freqWrAddr == lastAddr(NUM_FREQ));
  end

  // Time FSM with its RAM port, busy flag and done pulse. A frame strobe seen
  // while busy is remembered so the capture re-arms straight away at the end
  // instead of sitting in HOLD; a strobe on the final write counts the same.
  always_ff @(posedge ck100MHz or posedge rst) begin
    if (rst) begin
      timeState_q <= ARMED;
      timeAddr_q  <= '0;
      pending_q   <= 1'b0;
      enaTime_q   <= 1'b0;
      weaTime_q   <= 1'b0;
      addraTime_q <= '0;
      dinaTime_q  <= '0;
      timeBusy_q  <= 1'b0;
      capDone_q   <= 1'b0;
    end else begin
      enaTime_q <= 1'b0;
      weaTime_q <= 1'b0;
      capDone_q <= 1'b0;
      case (timeState_q)
        ARMED, CAPTURE: begin
          timeBusy_q <= 1'b1;
          if (bus.frmTick) begin
            pending_q <= 1'b1;
          end
          if (timeWrite) begin
            enaTime_q   <= 1'b1;
            weaTime_q   <= 1'b1;
            addraTime_q <= timeWrAddr;
            dinaTime_q  <= bus.timeData;
            if (timeLast) begin
              capDone_q  <= 1'b1;
              timeAddr_q <= '0;
              pending_q  <= 1'b0;
              if (pending_q || bus.frmTick) begin
                timeState_q <= ARMED;
              end else begin
                timeState_q <= HOLD;
                timeBusy_q  <= 1'b0;
              end
            end else begin
              timeAddr_q  <= timeWrAddr + ADDR_W'(1);
              timeState_q <= CAPTURE;
            end
          end
        end
        HOLD: begin
          if (bus.frmTick) begin
            timeState_q <= ARMED;
            timeBusy_q  <= 1'b1;
          end
        end
        default: begin
          timeState_q <= ARMED;
          timeAddr_q  <= '0;
        end
      endcase
    end
  end

  // Frequency FSM: a bin flagged first always restarts the fill at address 0,
  // and a full frame is frozen until the next frame strobe.
  always_ff @(posedge ck100MHz or posedge rst) begin
    if (rst) begin
      freqState_q <= FWAIT;
      freqAddr_q  <= '0;
      weaFreq_q   <= 1'b0;
      addraFreq_q <= '0;
      dinaFreq_q  <= '0;
    end else begin
      weaFreq_q <= 1'b0;
      case (freqState_q)
        FWAIT, FFILL: begin
          if (freqWrite) begin
            weaFreq_q   <= 1'b1;
            addraFreq_q <= freqWrAddr;
            dinaFreq_q  <= bus.freqData;
            if (freqLast) begin
              freqState_q <= FDONE;
              freqAddr_q  <= '0;
            end else begin
              freqState_q <= FFILL;
              freqAddr_q  <= freqWrAddr + ADDR_W'(1);
            end
          end
        end
        FDONE: begin
          if (bus.frmTick) begin
            freqState_q <= FWAIT;
          end
        end
        default: begin
          freqState_q <= FWAIT;
          freqAddr_q  <= '0;
        end
      endcase
    end
  end

  assign bus.enaTime   = enaTime_q;
  assign bus.weaTime   = weaTime_q;
  assign bus.addraTime = addraTime_q;
  assign bus.dinaTime  = dinaTime_q;
  assign bus.weaFreq   = weaFreq_q;
  assign bus.addraFreq = addraFreq_q;
  assign bus.dinaFreq  = dinaFreq_q;
  assign bus.timeBusy  = timeBusy_q;
  assign bus.capDone   = capDone_q;

endmodule

// File: tb/tb_disp_capture_sched.sv
// Directed, self-checking bench for disp_capture_sched.
// Works with DISP_CAPTURE_TRIG_EN defined or undefined; the arming step and
// the timeout sequence follow whichever build is compiled.
module tb_disp_capture_sched;
  import disp_pkg::*;

  localparam int NT = 640;
  localparam int NF = 80;
  localparam int TO = 4096;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
`ifdef DISP_CAPTURE_TRIG_EN
  localparam logic [7:0] FIRST = 8'h03;
`else
  localparam logic [7:0] FIRST = 8'h80;
`endif

  logic ck100MHz = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  disp_capture_sched_if bus ();

  disp_capture_sched #(.NUM_TIME(NT), .NUM_FREQ(NF), .TRIG_TIMEOUT(TO)) dut (
    .ck100MHz (ck100MHz),
    .rst      (rst),
    .bus      (bus)
  );

  // 100 MHz clock
  always #5 ck100MHz = ~ck100MHz;

  // Stimulus/expectation record for the table-driven part
  typedef struct {
    logic frm; logic tv; logic [7:0] td; logic fv; logic ff; logic [7:0] fd;
    logic weaT; int addrT; logic [7:0] dinT;
    logic weaF; int addrF; logic [7:0] dinF;
    logic busy; logic done;
  } vec_t;

  vec_t vecs[8];

  // Compare one value and report a failure line if it differs
  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs; returns #1 after the sampling edge
  task automatic applyStimulus(input logic frm, input logic tv, input logic [7:0] td,
                               input logic fv, input logic ff, input logic [7:0] fd);
    @(negedge ck100MHz);
    bus.frmTick   = frm;
    bus.timeVld   = tv;
    bus.timeData  = td;
    bus.freqVld   = fv;
    bus.freqFirst = ff;
    bus.freqData  = fd;
    @(posedge ck100MHz);
    #1;
    bus.frmTick   = 1'b0;
    bus.timeVld   = 1'b0;
    bus.freqVld   = 1'b0;
    bus.freqFirst = 1'b0;
  endtask

  // Compare the registered outputs against a table record
  task automatic checkOutput(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    checkVal({t, " weaTime"}, int'(bus.weaTime), int'(v.weaT));
    checkVal({t, " enaTime"}, int'(bus.enaTime), int'(v.weaT));
    if (v.weaT) begin
      checkVal({t, " addraTime"}, int'(bus.addraTime), v.addrT);
      checkVal({t, " dinaTime"}, int'(bus.dinaTime), int'(v.dinT));
    end
    checkVal({t, " weaFreq"}, int'(bus.weaFreq), int'(v.weaF));
    if (v.weaF) begin
      checkVal({t, " addraFreq"}, int'(bus.addraFreq), v.addrF);
      checkVal({t, " dinaFreq"}, int'(bus.dinaFreq), int'(v.dinF));
    end
    checkVal({t, " timeBusy"}, int'(bus.timeBusy), int'(v.busy));
    checkVal({t, " capDone"}, int'(bus.capDone), int'(v.done));
  endtask

  task automatic checkAllZero(input string t);
    checkVal({t, " enaTime"}, int'(bus.enaTime), 0);
    checkVal({t, " weaTime"}, int'(bus.weaTime), 0);
    checkVal({t, " addraTime"}, int'(bus.addraTime), 0);
    checkVal({t, " dinaTime"}, int'(bus.dinaTime), 0);
    checkVal({t, " weaFreq"}, int'(bus.weaFreq), 0);
    checkVal({t, " addraFreq"}, int'(bus.addraFreq), 0);
    checkVal({t, " dinaFreq"}, int'(bus.dinaFreq), 0);
    checkVal({t, " timeBusy"}, int'(bus.timeBusy), 0);
    checkVal({t, " capDone"}, int'(bus.capDone), 0);
  endtask

  // From ARMED: in the trigger build feed -5,-1 (no write) then the first
  // sample; free-running writes the first sample straight away.
  task automatic armCapture(input string t);
`ifdef DISP_CAPTURE_TRIG_EN
    applyStimulus(L, H, 8'hFB, L, L, 8'h00);
    checkVal({t, " pre -5 weaTime"}, int'(bus.weaTime), 0);
    applyStimulus(L, H, 8'hFF, L, L, 8'h00);
    checkVal({t, " pre -1 weaTime"}, int'(bus.weaTime), 0);
`endif
    applyStimulus(L, H, FIRST, L, L, 8'h00);
    checkVal({t, " first weaTime"}, int'(bus.weaTime), 1);
    checkVal({t, " first addraTime"}, int'(bus.addraTime), 0);
    checkVal({t, " first dinaTime"}, int'(bus.dinaTime), int'(FIRST));
    checkVal({t, " first capDone"}, int'(bus.capDone), 0);
    checkVal({t, " first timeBusy"}, int'(bus.timeBusy), 1);
  endtask

  // Write addresses from..NT-1 with data addr^0x5A; capDone only on the last
  task automatic captureRest(input int from, input logic frmAtLast,
                             input logic busyAfter, input string t);
    for (int a = from; a < NT; a++) begin
      logic last;
      logic [7:0] d;
      last = (a == NT - 1);
      d = 8'(a) ^ 8'h5A;
      applyStimulus(last & frmAtLast, H, d, L, L, 8'h00);
      checkVal({t, " weaTime"}, int'(bus.weaTime), 1);
      checkVal({t, " addraTime"}, int'(bus.addraTime), a);
      checkVal({t, " dinaTime"}, int'(bus.dinaTime), int'(d));
      checkVal({t, " capDone"}, int'(bus.capDone), int'(last));
      if (last) checkVal({t, " timeBusy after last"}, int'(bus.timeBusy), int'(busyAfter));
    end
  endtask

  // Overall time limit so the bench always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pulses;
    //            frm tv  td     fv ff fd      weaT addrT dinT   weaF addrF dinF  busy done
    vecs[0] = '{L, L, 8'h00, L, L, 8'h00,  L, 0, 8'h00,  L, 0, 8'h00,  H, L};
    vecs[1] = '{L, H, 8'h07, L, L, 8'h00,  H, 1, 8'h07,  L, 0, 8'h00,  H, L};
    vecs[2] = '{L, H, 8'hFB, H, H, 8'h11,  H, 2, 8'hFB,  H, 0, 8'h11,  H, L};
    vecs[3] = '{L, L, 8'h00, H, L, 8'h22,  L, 0, 8'h00,  H, 1, 8'h22,  H, L};
    vecs[4] = '{L, L, 8'h00, H, H, 8'h33,  L, 0, 8'h00,  H, 0, 8'h33,  H, L};
    vecs[5] = '{L, L, 8'h00, H, L, 8'h44,  L, 0, 8'h00,  H, 1, 8'h44,  H, L};
    vecs[6] = '{H, H, 8'h10, L, L, 8'h00,  H, 3, 8'h10,  L, 0, 8'h00,  H, L};
    vecs[7] = '{L, H, 8'h20, H, L, 8'h55,  H, 4, 8'h20,  H, 2, 8'h55,  H, L};

    bus.frmTick = 1'b0; bus.timeVld = 1'b0; bus.timeData = 8'h00;
    bus.freqVld = 1'b0; bus.freqFirst = 1'b0; bus.freqData = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge ck100MHz);
    #1;
    checkAllZero("reset");
    @(negedge ck100MHz);
    rst = 1'b0;

    // First capture start, then the table (frmTick in vec6 leaves a pending flag)
    armCapture("arm1");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].frm, vecs[i].tv, vecs[i].td, vecs[i].fv, vecs[i].ff, vecs[i].fd);
      checkOutput(vecs[i], i);
    end

    // Frequency frame: 100 bins, only the first 80 are written
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(L, L, 8'h00, H, (i == 0), 8'(i + 1));
      if (bus.weaFreq) pulses++;
      if (i < NF) begin
        checkVal("fill addraFreq", int'(bus.addraFreq), i);
        checkVal("fill dinaFreq", int'(bus.dinaFreq), i + 1);
      end else begin
        checkVal("fdone weaFreq", int'(bus.weaFreq), 0);
      end
    end
    checkVal("freq pulse count", pulses, NF);
    applyStimulus(L, L, 8'h00, H, H, 8'hAA);
    checkVal("fdone first ignored", int'(bus.weaFreq), 0);
    applyStimulus(H, L, 8'h00, L, L, 8'h00);
    checkVal("frmTick freq no write", int'(bus.weaFreq), 0);
    applyStimulus(L, L, 8'h00, H, L, 8'hBB);
    checkVal("fwait needs first", int'(bus.weaFreq), 0);
    applyStimulus(L, L, 8'h00, H, H, 8'hCC);
    checkVal("refill weaFreq", int'(bus.weaFreq), 1);
    checkVal("refill addraFreq", int'(bus.addraFreq), 0);
    checkVal("refill dinaFreq", int'(bus.dinaFreq), 8'hCC);

    // Pending strobe: end of buffer goes straight back to ARMED
    captureRest(5, L, H, "run1");
    armCapture("arm2");

    // No strobe: HOLD ignores samples until frmTick
    captureRest(1, L, L, "run2");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(L, H, 8'h01, L, L, 8'h00);
      checkVal("hold weaTime", int'(bus.weaTime), 0);
      checkVal("hold timeBusy", int'(bus.timeBusy), 0);
    end
    applyStimulus(H, L, 8'h00, L, L, 8'h00);
    checkVal("hold->armed timeBusy", int'(bus.timeBusy), 1);
    checkVal("hold->armed weaTime", int'(bus.weaTime), 0);

    // Strobe on the final write behaves like a pending flag
    armCapture("arm3");
    captureRest(1, H, H, "run3");
    armCapture("arm4");

    // Async reset during the write at address 100
    for (int a = 1; a <= 100; a++) begin
      applyStimulus(L, H, 8'(a), L, L, 8'h00);
    end
    checkVal("pre-reset addraTime", int'(bus.addraTime), 100);
    checkVal("pre-reset weaTime", int'(bus.weaTime), 1);
    #1 rst = 1'b1;
    #1 checkAllZero("async reset");
    repeat (2) @(posedge ck100MHz);
    @(negedge ck100MHz);
    rst = 1'b0;
    applyStimulus(L, L, 8'h00, L, L, 8'h00);
    checkVal("post-reset capDone", int'(bus.capDone), 0);
    checkVal("post-reset weaTime", int'(bus.weaTime), 0);
    armCapture("arm5");
    captureRest(1, L, L, "run4");

`ifdef DISP_CAPTURE_TRIG_EN
    // Constant +10 never crosses zero: the timeout forces the capture
    applyStimulus(H, L, 8'h00, L, L, 8'h00);
    pulses = 0;
    for (int i = 0; i < TO; i++) begin
      applyStimulus(L, H, 8'h0A, L, L, 8'h00);
      if (bus.weaTime) pulses++;
    end
    checkVal("timeout no early writes", pulses, 0);
    applyStimulus(L, H, 8'h0A, L, L, 8'h00);
    checkVal("forced weaTime", int'(bus.weaTime), 1);
    checkVal("forced addraTime", int'(bus.addraTime), 0);
    checkVal("forced dinaTime", int'(bus.dinaTime), 8'h0A);
    captureRest(1, L, L, "run5");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_capture_sched.md
DISP_CAPTURE_SCHED -- requirements
Module: disp_capture_sched

Interface
REQ-001 Parameter NUM_TIME, default 640, time samples written per capture (display columns).
REQ-002 Parameter NUM_FREQ, default 80, frequency bins written per frame (640/8 columns).
REQ-003 Parameter TRIG_TIMEOUT, default 4096, accepted samples to wait for a trigger before forced capture.
REQ-004 One clock and one reset: reset is asynchronous, active-high.
REQ-005 ck100MHz  in  1  system clock; every output is registered on its rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 frmTick  in  1  one-cycle frame strobe, already synchronous to ck100MHz.
REQ-008 timeVld  in  1  time sample valid; timeData  in  8  signed two's-complement sample.
REQ-009 freqVld  in  1  bin valid; freqFirst  in  1  marks bin 0; freqData  in  8  unsigned magnitude.
REQ-010 enaTime, weaTime  out  1 each; addraTime  out  10; dinaTime  out  8  time display RAM write port.
REQ-011 weaFreq  out  1; addraFreq  out  10; dinaFreq  out  8  frequency display RAM write port.
REQ-012 timeBusy  out  1  high in ARMED or CAPTURE; capDone  out  1  one-cycle pulse after the last time write.

Function
REQ-013 Time FSM states SHALL be ARMED, CAPTURE and HOLD.
REQ-014 ARMED: on timeVld, the FSM SHALL register the sample as prev. If prev<0 and the current sample>=0 (signed), it SHALL write the current sample at address 0 and enter CAPTURE.
REQ-015 ARMED: if TRIG_TIMEOUT samples are accepted without a trigger, the next accepted sample SHALL be written at address 0 and the FSM SHALL enter CAPTURE (auto mode).
REQ-016 CAPTURE: each timeVld SHALL write timeData at an address incremented by 1. After the write at NUM_TIME-1, the FSM SHALL pulse capDone and enter HOLD.
REQ-017 HOLD: samples SHALL be ignored; frmTick SHALL move the FSM to ARMED and clear the timeout counter and prev.
REQ-018 A frmTick seen during ARMED or CAPTURE SHALL set a pending flag. Entering HOLD with the flag set SHALL go directly to ARMED, and the flag SHALL clear.
REQ-019 frmTick in the same cycle as the final CAPTURE write SHALL have the same effect as a pending flag.
REQ-020 Write latency: enaTime=weaTime=1 with address and data SHALL appear exactly one cycle after the accepting edge, for one cycle per sample.
REQ-021 Freq FSM states SHALL be FWAIT, FFILL and FDONE.
REQ-022 FWAIT: freqVld&&freqFirst SHALL write bin 0 at addraFreq 0 and enter FFILL.
REQ-023 FFILL: each freqVld SHALL write the next address. After address NUM_FREQ-1 the FSM SHALL enter FDONE.
REQ-024 FFILL: freqFirst asserted mid-fill SHALL restart the fill at address 0.
REQ-025 FDONE: bins SHALL be ignored until frmTick returns the FSM to FWAIT.
REQ-026 weaFreq SHALL follow the same one-cycle latency as the time port.
REQ-027 Address counters SHALL be 10 bits and never exceed NUM_TIME-1 or NUM_FREQ-1. Upper address bits SHALL be zero-extended.

Reset
REQ-028 On rst: the time FSM SHALL go to ARMED and the freq FSM to FWAIT.
REQ-029 On rst: all counters, prev and the pending flag SHALL clear, and every output SHALL be 0.
REQ-030 A write in flight when rst asserts SHALL be dropped, and no partial-frame completion pulse SHALL follow.

Configuration
REQ-031 Macro DISP_CAPTURE_TRIG_EN defined: trigger and timeout behaviour SHALL be as in REQ-014/015.
REQ-032 Macro DISP_CAPTURE_TRIG_EN undefined: ARMED SHALL start capture on the first accepted sample (free-running). The trigger comparator and timeout counter SHALL not be built.

Structure
REQ-033 Shared package disp_pkg SHALL hold the FSM state enums, default NUM_TIME/NUM_FREQ, and the 10-bit address and 8-bit sample widths.
REQ-034 Sub-module disp_trig_detect SHALL contain the prev register, the zero-crossing compare and the timeout counter. It SHALL be instantiated only under DISP_CAPTURE_TRIG_EN.

Verification
REQ-035 The bench SHALL cover: sample stream -5,-1,+3,+7,... after reset -> first write addr 0 data 0x03, then addr 1 data 0x07; capDone after the addr 639 write; timeBusy=0.
REQ-036 The bench SHALL cover: constant +10 for 4096 samples -> forced capture; next sample written at addr 0; 640 writes total.
REQ-037 The bench SHALL cover: frmTick during CAPTURE at addr 300 -> no restart; after addr 639, the FSM is ARMED in the next cycle with no HOLD wait.
REQ-038 The bench SHALL cover: freq bins with freqFirst, 100 values -> exactly 80 weaFreq pulses at addresses 0..79; the remaining 20 are ignored until frmTick.
REQ-039 The bench SHALL cover: rst asserted at time addr 100 -> outputs 0 immediately (asynchronous); the next capture starts at addr 0 with no capDone.
REQ-040 The bench SHALL cover: DISP_CAPTURE_TRIG_EN undefined, first sample 0x80 -> written at addr 0 in the next cycle.
